tmds_encoder_dvi: RTL and testbench

- DVI 1.0 TMDS 8b/10b encoder: one instance per colour channel inside the DVI output path.
- Consumes pixel-clock-domain 8-bit colour data, data-enable and 2-bit control from the display pipeline.
- Produces a DC-balanced, transition-minimised 10-bit symbol per pixel clock for the 5x serialiser.
- Fixed two-stage pipeline; fully synchronous to the pixel clock.

---
 rtl/dvi_pkg.sv | 54 +++++
 rtl/tmds_encoder_dvi.sv | 69 ++++++
 tb/tb_tmds_encoder_dvi.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dvi_pkg.sv
// Shared DVI/HDMI symbol constants and TMDS helper functions.
// Control tokens are reused by the TERC4 and HDMI encoders.
package dvi_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef struct packed {
        logic       de;
        logic [1:0] ctrl;
        logic [8:0] q_m;
    } tmds_stage1_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] c);
        logic [SYM_W-1:0] t;
        unique case (c)
            2'b00:   t = CTRL_TOKEN_00;
            2'b01:   t = CTRL_TOKEN_01;
            2'b10:   t = CTRL_TOKEN_10;
            default: t = CTRL_TOKEN_11;
        endcase
        return t;
    endfunction

    // Transition-minimising stage: bit 8 set means the XOR chain was used.
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1d;
        logic       use_xnor;
        n1d      = popcount8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

endpackage

// File: rtl/tmds_encoder_dvi.sv
// DVI 1.0 TMDS 8b/10b encoder, one colour channel.
// Two register stages: transition minimising, then DC balancing.
module tmds_encoder_dvi
    import dvi_pkg::*;
(
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             de,
    input  logic [7:0]       din,
    input  logic [1:0]       ctrl,
    output logic [SYM_W-1:0] tmds
);

    tmds_stage1_t     s1;
    tmds_stage1_t     s1_nxt;
    logic signed [4:0] cnt;
    logic signed [4:0] cnt_nxt;
    logic [SYM_W-1:0] sym_nxt;

    logic [7:0]        q;
    logic              q8;
    logic [3:0]        n1;
    logic [3:0]        n0;
    logic signed [4:0] disp;

    always_comb begin
        s1_nxt.de   = de;
        s1_nxt.ctrl = ctrl;
        s1_nxt.q_m  = tmds_qm(din);
    end

    assign q    = s1.q_m[7:0];
    assign q8   = s1.q_m[8];
    assign n1   = popcount8(q);
    assign n0   = 4'd8 - n1;
    assign disp = $signed({1'b0, n1}) - $signed({1'b0, n0});

    // Bias is dropped during blanking so each active line starts balanced.
    always_comb begin
        sym_nxt = ctrl_token(s1.ctrl);
        cnt_nxt = '0;
        if (s1.de) begin
            if ((cnt == 5'sd0) || (n1 == n0)) begin
                sym_nxt = {~q8, q8, (q8 ? q : ~q)};
                cnt_nxt = cnt + (q8 ? disp : -disp);
            end else if (((cnt > 5'sd0) && (n1 > n0)) ||
                         ((cnt < 5'sd0) && (n0 > n1))) begin
                sym_nxt = {1'b1, q8, ~q};
                cnt_nxt = cnt + (q8 ? 5'sd2 : 5'sd0) - disp;
            end else begin
                sym_nxt = {1'b0, q8, q};
                cnt_nxt = cnt + disp - (q8 ? 5'sd0 : 5'sd2);
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            s1   <= '0;
            cnt  <= '0;
            tmds <= CTRL_TOKEN_00;
        end else begin
            s1   <= s1_nxt;
            cnt  <= cnt_nxt;
            tmds <= sym_nxt;
        end
    end

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Randomised bench for the TMDS encoder against an arithmetic reference.
// Also decodes every symbol and watches the bias register.
module tb_tmds_encoder_dvi;

    logic       clk_pix = 1'b0;
    logic       rst_pix;
    logic       de;
    logic [7:0] din;
    logic [1:0] ctrl;
    logic [9:0] tmds;

    int errors = 0;
    int checks = 0;

    logic [9:0] tok [4];

    int         mcnt;
    bit         p_de;
    logic [7:0] p_din;
    logic [1:0] p_ctrl;
    bit         o_valid;
    bit         o_de;
    logic [7:0] o_din;
    logic [1:0] o_ctrl;

    always #5 clk_pix = ~clk_pix;

    tmds_encoder_dvi dut (
        .clk_pix(clk_pix),
        .rst_pix(rst_pix),
        .de     (de),
        .din    (din),
        .ctrl   (ctrl),
        .tmds   (tmds)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: XOR chain bit i is the parity of d[0..i]; XNOR adds i mod 2.
    task automatic model_enc(input bit e, input logic [7:0] d,
                             input logic [1:0] c, output logic [9:0] sym);
        logic [7:0] qm;
        int n1d, n1, n0, q8;
        bit xn;
        if (!e) begin
            mcnt = 0;
            sym  = tok[c];
            return;
        end
        n1d = $countones(d);
        xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        for (int i = 0; i < 8; i++) begin
            qm[i] = (^(d & 8'((1 << (i + 1)) - 1))) ^ (xn && (i % 2 == 1));
        end
        q8 = xn ? 0 : 1;
        n1 = $countones(qm);
        n0 = 8 - n1;
        if (mcnt == 0 || n1 == n0) begin
            sym  = {~q8[0], q8[0], (q8 == 1) ? qm : ~qm};
            mcnt = mcnt + ((q8 == 1) ? (n1 - n0) : (n0 - n1));
        end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
            sym  = {1'b1, q8[0], ~qm};
            mcnt = mcnt + 2 * q8 + (n0 - n1);
        end else begin
            sym  = {1'b0, q8[0], qm};
            mcnt = mcnt + (n1 - n0) - 2 * (1 - q8);
        end
    endtask

    function automatic logic [7:0] decode_data(input logic [9:0] s);
        logic [7:0] qv;
        logic [7:0] d;
        qv   = s[9] ? ~s[7:0] : s[7:0];
        d[0] = qv[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = qv[i] ^ qv[i-1] ^ ~s[8];
        end
        return d;
    endfunction

    function automatic int decode_ctrl(input logic [9:0] s);
        for (int i = 0; i < 4; i++) begin
            if (s == tok[i]) return i;
        end
        return 4;
    endfunction

    task automatic cyc(input bit r, input bit e, input logic [7:0] d,
                       input logic [1:0] c);
        logic [9:0] exp;
        int hc;
        rst_pix = r;
        de      = e;
        din     = d;
        ctrl    = c;
        @(posedge clk_pix);
        if (r) begin
            exp     = tok[0];
            mcnt    = 0;
            p_de    = 1'b0;
            p_din   = '0;
            p_ctrl  = '0;
            o_valid = 1'b0;
        end else begin
            model_enc(p_de, p_din, p_ctrl, exp);
            o_valid = 1'b1;
            o_de    = p_de;
            o_din   = p_din;
            o_ctrl  = p_ctrl;
            p_de    = e;
            p_din   = d;
            p_ctrl  = c;
        end
        #1;
        check("tmds", 32'(tmds), 32'(exp));
        hc = int'(dut.cnt);
        check("cnt", hc, mcnt);
        check("cnt_range", 32'((hc % 2 == 0) && hc >= -10 && hc <= 10), 1);
        if (o_valid) begin
            if (o_de) check("dec_din", 32'(decode_data(tmds)), 32'(o_din));
            else check("dec_ctrl", decode_ctrl(tmds), 32'(o_ctrl));
        end
        @(negedge clk_pix);
    endtask

    task automatic blank();
        cyc(1'b0, 1'b0, 8'($urandom), 2'b00);
    endtask

    initial begin
        int  left;
        bit  cur_de;
        tok[0] = 10'b1101010100;
        tok[1] = 10'b0010101011;
        tok[2] = 10'b0101010100;
        tok[3] = 10'b1010101011;
        mcnt = 0; p_de = 0; p_din = 0; p_ctrl = 0; o_valid = 0;
        rst_pix = 1'b1; de = 1'b0; din = '0; ctrl = '0;
        @(negedge clk_pix);

        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'($urandom), 8'($urandom), 2'($urandom));
            check("rst_tok", 32'(tmds), 32'(10'b1101010100));
        end
        cyc(1'b0, 1'b1, 8'hA5, 2'b11);
        check("post_rst_tok", 32'(tmds), 32'(10'b1101010100));
        cyc(1'b0, 1'b0, 8'h00, 2'b00);

        cyc(1'b0, 1'b0, 8'h3C, 2'b00);
        cyc(1'b0, 1'b0, 8'h3C, 2'b01);
        check("tok00", 32'(tmds), 32'(10'b1101010100));
        cyc(1'b0, 1'b0, 8'h3C, 2'b10);
        check("tok01", 32'(tmds), 32'(10'b0010101011));
        cyc(1'b0, 1'b0, 8'h3C, 2'b11);
        check("tok10", 32'(tmds), 32'(10'b0101010100));
        cyc(1'b0, 1'b0, 8'h3C, 2'b00);
        check("tok11", 32'(tmds), 32'(10'b1010101011));

        blank(); blank();
        cyc(1'b0, 1'b1, 8'h00, 2'b00);
        cyc(1'b0, 1'b1, 8'h00, 2'b00);
        check("bias1", 32'(tmds), 32'(10'b0100000000));
        cyc(1'b0, 1'b1, 8'h00, 2'b00);
        check("bias2", 32'(tmds), 32'(10'b1111111111));
        blank();
        check("bias3", 32'(tmds), 32'(10'b0100000000));

        blank(); blank();
        cyc(1'b0, 1'b1, 8'hFF, 2'b00);
        cyc(1'b0, 1'b1, 8'h0F, 2'b00);
        check("xnor_ff", 32'(tmds), 32'(10'b1000000000));
        blank();

        blank(); blank();
        cyc(1'b0, 1'b1, 8'h00, 2'b00);
        blank();
        check("blank_b1", 32'(tmds), 32'(10'b0100000000));
        cyc(1'b0, 1'b1, 8'h00, 2'b00);
        check("blank_tok", 32'(tmds), 32'(10'b1101010100));
        blank();
        check("blank_b2", 32'(tmds), 32'(10'b0100000000));

        left   = 0;
        cur_de = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (left == 0) begin
                cur_de = ~cur_de;
                left   = cur_de ? $urandom_range(1, 60) : $urandom_range(1, 6);
            end
            left--;
            cyc((i == 9000 || i == 9001), cur_de, 8'($urandom), 2'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
